seq_scan_ctrl: RTL and testbench

//  Run-time controller for serial pattern detection on a 1-bit input stream.

---
 rtl/seq_scan_pkg.sv | 14 +
 rtl/seq_shift_cmp.sv | 61 ++++++
 rtl/seq_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seq_scan_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types and default sizes for the serial pattern scan controller.
package seq_scan_pkg;

    localparam int unsigned MAX_LEN_DEF = 8;
    localparam int unsigned LEN_W_DEF   = 4;
    localparam int unsigned CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/seq_shift_cmp.sv
// History shift register, fill counter and length-masked pattern compare.
// The hit output is combinational, computed from the post-shift history and fill.
module seq_shift_cmp
    import seq_scan_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
    logic [MAX_LEN-1:0] mask;

    // Post-shift view of history/fill, compare mask and next-state selection.
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], din};
        fill_inc   = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_q + 1'b1;

        mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (i < int'(len)) begin
                mask[i] = 1'b1;
            end
        end

        hit = shift_en && (fill_inc >= len) && (((hist_shift ^ pattern) & mask) == '0);

        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = hist_shift;
            // Non-overlapping mode restarts the fill so the next match needs fresh bits.
            fill_d = (hit && !overlap) ? '0 : fill_inc;
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Run-time controller for programmable serial pattern detection: config
// handshake, IDLE/RUN/DONE sequencing, saturating match counter and threshold.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_threshold,
    input  logic               start,
    input  logic               stop,
    input  logic               in,
    input  logic               in_valid,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   thr_q;
    logic [CNT_W-1:0]   count_q, count_d, count_inc;
    logic               match_q;
    logic               cfg_take;
    logic               clear;
    logic               shift_en;
    logic               hit;

    seq_shift_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shift_cmp (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift_en (shift_en),
        .din      (in),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .hit      (hit)
    );

    // Config is writable only outside RUN; illegal lengths complete the handshake but are dropped.
    always_comb begin
        cfg_ready = (state_q == S_IDLE) || (state_q == S_DONE);
        cfg_take  = cfg_valid && cfg_ready && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    end

    // Config registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
            ovl_q <= 1'b0;
            thr_q <= '0;
        end else if (cfg_take) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            thr_q <= cfg_threshold;
        end
    end

    // FSM next state, detector control and saturating match counter.
    always_comb begin
        state_d   = state_q;
        clear     = 1'b0;
        shift_en  = 1'b0;
        count_inc = (&count_q) ? count_q : count_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop && (len_q != '0)) begin
                    state_d = S_RUN;
                    clear   = 1'b1;
                end
            end
            S_RUN: begin
                shift_en = in_valid;
                // Stop wins over completion; a same-cycle hit is still counted.
                if (stop) begin
                    state_d = S_IDLE;
                end else if (hit && (thr_q != '0) && (count_inc == thr_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                    clear   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (hit) begin
            count_d = count_inc;
        end
    end

    // State, counter and registered match pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            match_q <= hit;
        end
    end

    // Status outputs.
    always_comb begin
        match       = match_q;
        match_count = count_q;
        busy        = (state_q == S_RUN);
        done        = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl; a second instance with a 2-bit counter checks saturation.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready, cfg_ready2;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_threshold;
    logic       start, stop, din, in_valid;
    logic       match, match2;
    logic [7:0] match_count;
    logic [1:0] match_count2;
    logic       busy, busy2, done, done2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_overlap   (cfg_overlap),
        .cfg_threshold (cfg_threshold),
        .start         (start),
        .stop          (stop),
        .in            (din),
        .in_valid      (in_valid),
        .match         (match),
        .match_count   (match_count),
        .busy          (busy),
        .done          (done)
    );

    seq_scan_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready2),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_overlap   (cfg_overlap),
        .cfg_threshold (cfg_threshold[1:0]),
        .start         (start),
        .stop          (stop),
        .in            (din),
        .in_valid      (in_valid),
        .match         (match2),
        .match_count   (match_count2),
        .busy          (busy2),
        .done          (done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        din      = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic gap();
        din      = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic send4(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) send(bits[i]);
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                             input logic [7:0] thr);
        cfg_valid     = 1'b1;
        cfg_pattern   = pat;
        cfg_len       = len;
        cfg_overlap   = ovl;
        cfg_threshold = thr;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_threshold = '0; start = 1'b0; stop = 1'b0; din = 1'b0; in_valid = 1'b0;
        tick();
        tick();
        check("rst_match", match, 0);
        check("rst_count", match_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;
        tick();

        // Unconfigured start is refused.
        pulse_start();
        check("start_unconfigured", busy, 0);

        // 1: 0111, non-overlap, no threshold.
        configure(8'b0111, 4'd4, 1'b0, 8'd0);
        pulse_start();
        check("t1_busy", busy, 1);
        send(1'b0); send(1'b1); send(1'b1);
        check("t1_no_early_match", match, 0);
        send(1'b1);
        check("t1_match", match, 1);
        check("t1_count", match_count, 1);
        tick();
        check("t1_match_one_cycle", match, 0);
        check("t1_busy_stays", busy, 1);

        // 2: pattern 11 with and without overlap.
        pulse_stop();
        check("t2_stop_idle", busy, 0);
        check("t2_count_held", match_count, 1);
        configure(8'b11, 4'd2, 1'b1, 8'd0);
        pulse_start();
        check("t2_count_cleared", match_count, 0);
        send(1'b1); send(1'b1); send(1'b1);
        check("t2_overlap_count", match_count, 2);
        pulse_stop();
        configure(8'b11, 4'd2, 1'b0, 8'd0);
        pulse_start();
        send(1'b1); send(1'b1); send(1'b1);
        check("t2_nonoverlap_count", match_count, 1);
        check("t2_no_third_match", match, 0);

        // 3: threshold of 2 ends the run.
        pulse_stop();
        configure(8'b0111, 4'd4, 1'b0, 8'd2);
        pulse_start();
        send4(4'b0111);
        check("t3_first_count", match_count, 1);
        check("t3_still_busy", busy, 1);
        send4(4'b0111);
        check("t3_match", match, 1);
        check("t3_done", done, 1);
        check("t3_busy_low", busy, 0);
        check("t3_cfg_ready_done", cfg_ready, 1);
        send4(4'b0111);
        check("t3_ignored_match", match, 0);
        check("t3_frozen_count", match_count, 2);

        // 4: config blocked in RUN, stop mid-pattern, len 0 discarded.
        pulse_start();
        check("t4_restart_count", match_count, 0);
        cfg_valid = 1'b1; cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_threshold = 8'd0;
        #1;
        check("t4_cfg_ready_run", cfg_ready, 0);
        tick();
        cfg_valid = 1'b0;
        send4(4'b0111);
        check("t4_old_cfg_match", match, 1);
        check("t4_old_cfg_count", match_count, 1);
        send(1'b0); send(1'b1);
        pulse_stop();
        check("t4_stop_idle", busy, 0);
        check("t4_stop_count_held", match_count, 1);
        cfg_valid = 1'b1; cfg_pattern = 8'b11; cfg_len = 4'd0; cfg_threshold = 8'd0;
        #1;
        check("t4_cfg_ready_idle", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        pulse_start();
        check("t4_len0_kept_start", busy, 1);
        send4(4'b0111);
        check("t4_len0_kept_match", match, 1);
        send4(4'b0111);
        check("t4_threshold_kept", done, 1);

        // 5: in_valid gaps, then async reset mid-run.
        pulse_start();
        send(1'b0); gap(); send(1'b1); gap(); gap();
        check("t5_no_match_in_gap", match, 0);
        send(1'b1);
        check("t5_no_match_early", match, 0);
        send(1'b1);
        check("t5_gap_match", match, 1);
        check("t5_gap_count", match_count, 1);
        send(1'b0); send(1'b1); send(1'b1);
        din = 1'b1; in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_count", match_count, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_cfg_ready", cfg_ready, 1);
        tick();
        check("t5_rst_no_match", match, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        pulse_start();
        check("t5_rst_cleared_cfg", busy, 0);

        // 6: 2-bit counter saturates at 3 (wide instance counts on).
        configure(8'b11, 4'd2, 1'b1, 8'd0);
        pulse_start();
        for (int i = 0; i < 6; i++) send(1'b1);
        check("t6_wide_count", match_count, 5);
        check("t6_sat_count", match_count2, 3);
        check("t6_sat_busy", busy2, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
